// File: rtl/irq_vector_sched_if.sv
// Interrupt handshake between the interrupt controller/CPU side and the vector scheduler.
// The master drives pending status, ack and EOI; the scheduler (slave) drives the request, vector and status flags.
interface irq_vector_sched_if;
   logic [31:0] irq_status;
   logic        irq_ack;
   logic        eoi;
   logic        irq_req;
   logic [4:0]  irq_vec;
   logic        in_service;
   logic        timeout_err;

   modport master (
      output irq_status,
      output irq_ack,
      output eoi,
      input  irq_req,
      input  irq_vec,
      input  in_service,
      input  timeout_err
   );

   modport slave (
      input  irq_status,
      input  irq_ack,
      input  eoi,
      output irq_req,
      output irq_vec,
      output in_service,
      output timeout_err
   );
endinterface

// File: rtl/irq_vector_sched.sv
// Round-robin IRQ vector scheduler: presents one pending source to the CPU and tracks it
// until end-of-interrupt, or until a bounded in-service time expires.
module irq_vector_sched #(
   parameter int NUMSRC  = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic                PCLK,
   input  logic                PRESETn,
   irq_vector_sched_if.slave   irq_bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PEND   = 2'd1,
      ST_INSERV = 2'd2
   } state_t;

   localparam logic [31:0] SRC_MASK = (NUMSRC >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NUMSRC) - 32'd1);
   localparam logic [4:0]  LAST_IDX = 5'(NUMSRC - 1);
   localparam logic [5:0]  NUM_W    = 6'(NUMSRC);
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [4:0]  r_rr_ptr;
   logic [15:0] r_cnt;
   logic [4:0]  r_irq_vec;
   logic        r_irq_req;
   logic        r_in_service;
   logic        r_timeout_err;

   logic [31:0] w_valid_status;
   logic        w_vec_pending;
   logic        w_timeout_hit;
   logic        w_pick_vld;
   logic [4:0]  w_pick_idx;
   logic [5:0]  w_scan_sum;

   logic [4:0]  w_rr_nxt;
   logic [15:0] w_cnt_nxt;
   logic [4:0]  w_vec_nxt;
   logic        w_req_nxt;
   logic        w_ins_nxt;
   logic        w_terr_nxt;

   assign w_valid_status = irq_bus.irq_status & SRC_MASK;
   assign w_vec_pending  = w_valid_status[r_irq_vec];
   assign w_timeout_hit  = (r_cnt == CNT_LAST);

   // Round-robin search: first valid bit at or after rr_ptr, wrapping modulo NUMSRC.
   always_comb begin
      w_pick_vld = 1'b0;
      w_pick_idx = 5'd0;
      w_scan_sum = 6'd0;
      for (int i = 0; i < NUMSRC; i++) begin
         w_scan_sum = {1'b0, r_rr_ptr} + 6'(i);
         w_scan_sum = (w_scan_sum >= NUM_W) ? (w_scan_sum - NUM_W) : w_scan_sum;
         if (!w_pick_vld && w_valid_status[w_scan_sum[4:0]]) begin
            w_pick_vld = 1'b1;
            w_pick_idx = w_scan_sum[4:0];
         end else begin
            w_pick_idx = w_pick_idx;
         end
      end
   end

   // State register.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; ack beats a withdrawn source and eoi beats the timeout.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_vld) begin
               w_state_nxt = ST_PEND;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_PEND: begin
            if (irq_bus.irq_ack) begin
               w_state_nxt = ST_INSERV;
            end else if (!w_vec_pending) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_PEND;
            end
         end
         ST_INSERV: begin
            if (irq_bus.eoi || w_timeout_hit) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_INSERV;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Output/datapath next values, registered below so every output is a flop.
   always_comb begin
      w_req_nxt  = (w_state_nxt == ST_PEND);
      w_ins_nxt  = (w_state_nxt == ST_INSERV);
      w_terr_nxt = (r_state == ST_INSERV) && !irq_bus.eoi && w_timeout_hit;
      w_vec_nxt  = r_irq_vec;
      w_rr_nxt   = r_rr_ptr;
      w_cnt_nxt  = 16'd0;
      if ((r_state == ST_IDLE) && w_pick_vld) begin
         w_vec_nxt = w_pick_idx;
      end else begin
         w_vec_nxt = r_irq_vec;
      end
      if ((r_state == ST_PEND) && irq_bus.irq_ack) begin
         w_rr_nxt = (r_irq_vec == LAST_IDX) ? 5'd0 : (r_irq_vec + 5'd1);
      end else begin
         w_rr_nxt = r_rr_ptr;
      end
      if ((r_state == ST_INSERV) && (w_state_nxt == ST_INSERV)) begin
         w_cnt_nxt = r_cnt + 16'd1;
      end else begin
         w_cnt_nxt = 16'd0;
      end
   end

   // Registered outputs, round-robin pointer and in-service counter.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         r_rr_ptr      <= 5'd0;
         r_cnt         <= 16'd0;
         r_irq_vec     <= 5'd0;
         r_irq_req     <= 1'b0;
         r_in_service  <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_rr_ptr      <= w_rr_nxt;
         r_cnt         <= w_cnt_nxt;
         r_irq_vec     <= w_vec_nxt;
         r_irq_req     <= w_req_nxt;
         r_in_service  <= w_ins_nxt;
         r_timeout_err <= w_terr_nxt;
      end
   end

   assign irq_bus.irq_req     = r_irq_req;
   assign irq_bus.irq_vec     = r_irq_vec;
   assign irq_bus.in_service  = r_in_service;
   assign irq_bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_irq_vector_sched.sv
// Self-checking bench for irq_vector_sched: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level reference model.
module tb_irq_vector_sched;

   localparam int N  = 8;
   localparam int TO = 4;

   logic PCLK;
   logic PRESETn;
   int   checks;
   int   errors;

   irq_vector_sched_if bus ();

   irq_vector_sched #(.NUMSRC(N), .TIMEOUT(TO)) dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .irq_bus (bus)
   );

   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   // Reference model: 0 = nothing presented, 1 = vector presented, 2 = vector being serviced.
   int          m_phase;
   int          m_rr;
   int          m_vec;
   int          m_cyc;
   int          m_entry;
   bit          m_terr;

   task automatic model_step();
      logic [31:0] st;
      bit          found;
      int          idx;
      m_cyc++;
      st = bus.irq_status;
      if (!PRESETn) begin
         m_phase = 0; m_rr = 0; m_vec = 0; m_terr = 1'b0;
      end else begin
         m_terr = 1'b0;
         if (m_phase == 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
               idx = (m_rr + k) % N;
               if (!found && st[idx]) begin
                  found = 1'b1;
                  m_vec = idx;
               end
            end
            if (found) m_phase = 1;
         end else if (m_phase == 1) begin
            if (bus.irq_ack) begin
               m_phase = 2;
               m_rr    = (m_vec + 1) % N;
               m_entry = m_cyc;
            end else if (!st[m_vec]) begin
               m_phase = 0;
            end
         end else begin
            if (bus.eoi) begin
               m_phase = 0;
            end else if (m_cyc - m_entry == TO) begin
               m_phase = 0;
               m_terr  = 1'b1;
            end
         end
      end
   endtask

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic compare_model();
      check("model_irq_req",     int'(bus.irq_req),     (m_phase == 1) ? 1 : 0);
      check("model_in_service",  int'(bus.in_service),  (m_phase == 2) ? 1 : 0);
      check("model_irq_vec",     int'(bus.irq_vec),     m_vec);
      check("model_timeout_err", int'(bus.timeout_err), int'(m_terr));
   endtask

   // One clock: apply inputs, let the edge happen, advance the model, compare on the falling edge.
   task automatic tick(input logic [31:0] st, input logic ak, input logic eo, input logic rn);
      bus.irq_status = st;
      bus.irq_ack    = ak;
      bus.eoi        = eo;
      PRESETn        = rn;
      @(posedge PCLK);
      model_step();
      @(negedge PCLK);
      compare_model();
   endtask

   logic [31:0] r_st;

   initial begin
      checks = 0; errors = 0;
      m_phase = 0; m_rr = 0; m_vec = 0; m_cyc = 0; m_entry = 0; m_terr = 1'b0;
      bus.irq_status = 32'h0; bus.irq_ack = 1'b0; bus.eoi = 1'b0; PRESETn = 1'b0;

      // Reset with active inputs: they must be ignored.
      tick(32'h05, 1'b0, 1'b0, 1'b0);
      tick(32'h05, 1'b1, 1'b1, 1'b0);
      check("rst_irq_req", int'(bus.irq_req), 0);
      check("rst_irq_vec", int'(bus.irq_vec), 0);
      check("rst_in_service", int'(bus.in_service), 0);
      check("rst_timeout_err", int'(bus.timeout_err), 0);

      // 0x05: vector 0 first, then round-robin moves on to 2.
      tick(32'h05, 1'b0, 1'b0, 1'b1);
      check("rr05_req", int'(bus.irq_req), 1);
      check("rr05_vec0", int'(bus.irq_vec), 0);
      tick(32'h05, 1'b1, 1'b0, 1'b1);
      check("rr05_inserv", int'(bus.in_service), 1);
      check("rr05_req_low", int'(bus.irq_req), 0);
      tick(32'h05, 1'b0, 1'b1, 1'b1);
      check("rr05_eoi_idle", int'(bus.in_service), 0);
      tick(32'h05, 1'b0, 1'b0, 1'b1);
      check("rr05_vec2", int'(bus.irq_vec), 2);
      tick(32'h05, 1'b1, 1'b0, 1'b1);
      tick(32'h00, 1'b0, 1'b1, 1'b1);

      // Ack arriving in the same cycle the source drops still wins (rr is now 3).
      tick(32'h08, 1'b0, 1'b0, 1'b1);
      check("ackwin_vec3", int'(bus.irq_vec), 3);
      tick(32'h00, 1'b1, 1'b0, 1'b1);
      check("ackwin_inserv", int'(bus.in_service), 1);
      tick(32'h00, 1'b0, 1'b1, 1'b1);

      // Bits at or above NUMSRC never raise a request.
      tick(32'hFFFF_FF00, 1'b0, 1'b0, 1'b1);
      tick(32'hFFFF_FF00, 1'b0, 1'b0, 1'b1);
      check("upper_bits_ignored", int'(bus.irq_req), 0);

      // 0xFF held: nine services wrap 0..7,0.
      tick(32'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) begin
         tick(32'hFF, 1'b0, 1'b0, 1'b1);
         check("wrap_vec", int'(bus.irq_vec), i % 8);
         tick(32'hFF, 1'b1, 1'b0, 1'b1);
         tick(32'hFF, 1'b0, 1'b1, 1'b1);
      end

      // Withdrawal in PEND leaves rr untouched: 0x30 afterwards still picks 4.
      tick(32'h0, 1'b0, 1'b0, 1'b0);
      tick(32'h10, 1'b0, 1'b0, 1'b1);
      check("wd_vec4", int'(bus.irq_vec), 4);
      tick(32'h00, 1'b0, 1'b0, 1'b1);
      check("wd_req_fall", int'(bus.irq_req), 0);
      tick(32'h30, 1'b0, 1'b0, 1'b1);
      check("wd_re_vec4", int'(bus.irq_vec), 4);
      check("wd_re_req", int'(bus.irq_req), 1);

      // Timeout: pulse exactly one cycle, four cycles after in-service entry.
      tick(32'h0, 1'b0, 1'b0, 1'b0);
      tick(32'h01, 1'b0, 1'b0, 1'b1);
      tick(32'h00, 1'b1, 1'b0, 1'b1);
      for (int k = 1; k < 4; k++) begin
         tick(32'h00, 1'b0, 1'b0, 1'b1);
         check("to_still_inserv", int'(bus.in_service), 1);
         check("to_no_early_pulse", int'(bus.timeout_err), 0);
      end
      tick(32'h00, 1'b0, 1'b0, 1'b1);
      check("to_pulse", int'(bus.timeout_err), 1);
      check("to_released", int'(bus.in_service), 0);
      tick(32'h00, 1'b0, 1'b0, 1'b1);
      check("to_pulse_one_cycle", int'(bus.timeout_err), 0);

      // EOI in the timeout cycle suppresses the pulse.
      tick(32'h0, 1'b0, 1'b0, 1'b0);
      tick(32'h01, 1'b0, 1'b0, 1'b1);
      tick(32'h00, 1'b1, 1'b0, 1'b1);
      for (int k = 1; k < 4; k++) tick(32'h00, 1'b0, 1'b0, 1'b1);
      tick(32'h00, 1'b0, 1'b1, 1'b1);
      check("eoi_beats_to", int'(bus.timeout_err), 0);
      check("eoi_beats_to_idle", int'(bus.in_service), 0);
      tick(32'h00, 1'b0, 1'b0, 1'b1);
      check("eoi_beats_to_after", int'(bus.timeout_err), 0);

      // Reset during in-service abandons it; afterwards 0x80 gives vector 7.
      tick(32'h01, 1'b0, 1'b0, 1'b1);
      tick(32'h01, 1'b1, 1'b0, 1'b1);
      check("midrst_inserv", int'(bus.in_service), 1);
      tick(32'h01, 1'b0, 1'b0, 1'b0);
      check("midrst_req", int'(bus.irq_req), 0);
      check("midrst_vec", int'(bus.irq_vec), 0);
      check("midrst_ins", int'(bus.in_service), 0);
      check("midrst_terr", int'(bus.timeout_err), 0);
      tick(32'h80, 1'b0, 1'b0, 1'b1);
      check("midrst_vec7", int'(bus.irq_vec), 7);

      // Randomized traffic against the model.
      r_st = 32'h0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            r_st = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom();
         end
         tick(r_st,
              logic'($urandom_range(0, 2) == 0),
              logic'($urandom_range(0, 3) == 0),
              logic'($urandom_range(0, 99) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/irq_vector_sched.md
IRQ_VECTOR_SCHED -- requirements
Module: irq_vector_sched

Interface
REQ-001 SHALL have parameter NUMSRC, default 8, number of IRQ sources arbitrated (legal 1..32).
REQ-002 SHALL have parameter TIMEOUT, default 1024, maximum in-service cycles before forced release (legal 2..65535).
REQ-003 SHALL have port PCLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port PRESETn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port irq_status  input  32  masked, level-sensitive pending IRQ status from the interrupt controller; bits >= NUMSRC ignored.
REQ-006 SHALL have port irq_ack  input  1  CPU accepts the presented vector.
REQ-007 SHALL have port eoi  input  1  end-of-interrupt pulse for the in-service source.
REQ-008 SHALL have port irq_req  output  1  vector valid, request to CPU.
REQ-009 SHALL have port irq_vec  output  5  index of the selected source.
REQ-010 SHALL have port in_service  output  1  a source is acknowledged and awaiting EOI.
REQ-011 SHALL have port timeout_err  output  1  one-cycle pulse on forced release.

Function
REQ-012 SHALL implement states IDLE, PEND and INSERV, registered, one-hot or binary at implementer's choice.
REQ-013 IDLE: if any valid irq_status bit is set, SHALL select a source round-robin starting at index rr_ptr, latch it into irq_vec, and enter PEND on the next edge.
REQ-014 Round-robin search SHALL scan rr_ptr, rr_ptr+1, ... NUMSRC-1, 0, ... rr_ptr-1 and pick the first set bit; indices wrap modulo NUMSRC.
REQ-015 PEND: irq_req SHALL be 1 and irq_vec SHALL hold stable until leaving PEND.
REQ-016 PEND with irq_ack=1: SHALL enter INSERV; rr_ptr SHALL become (irq_vec+1) mod NUMSRC.
REQ-017 PEND with irq_ack=0 and latched source bit cleared: SHALL withdraw to IDLE; rr_ptr unchanged.
REQ-018 PEND with irq_ack=1 and latched source bit cleared in the same cycle: ack SHALL win (enter INSERV).
REQ-019 INSERV: in_service SHALL be 1, irq_req 0, irq_vec held; no new selection SHALL occur.
REQ-020 INSERV with eoi=1: SHALL enter IDLE; earliest next irq_req is 2 cycles after the eoi edge.
REQ-021 INSERV: a 16-bit counter SHALL clear on entry and increment each cycle; at count TIMEOUT-1 without eoi, SHALL enter IDLE and pulse timeout_err for exactly 1 cycle.
REQ-022 eoi and timeout in the same cycle: eoi SHALL win; timeout_err SHALL stay 0.
REQ-023 irq_ack in IDLE or INSERV, and eoi in IDLE or PEND, SHALL be ignored.
REQ-024 irq_req SHALL be a registered output (1 in PEND only); latency from irq_status assertion in IDLE to irq_req=1 is 1 cycle.

Reset
REQ-025 While PRESETn=0 at a rising PCLK edge: state SHALL be IDLE; rr_ptr 0; counter 0; irq_req 0; irq_vec 0; in_service 0; timeout_err 0.
REQ-026 Reset asserted mid-PEND or mid-INSERV SHALL abandon the transaction with no timeout_err pulse.
REQ-027 Inputs SHALL be ignored in the cycle PRESETn is low.

Verification
REQ-028 irq_status=0x05, reset released, irq_ack on first irq_req -> irq_vec=0, in_service=1; after eoi, next irq_vec=2 (round-robin).
REQ-029 irq_status=0xFF held, ack+eoi repeated 9 times -> vectors 0,1,...,7,0 (wrap).
REQ-030 irq_status=0x10, drop to 0 during PEND without ack -> irq_req falls the next cycle, rr_ptr unchanged, next 0x10 re-presents vec 4.
REQ-031 TIMEOUT=4, ack then no eoi -> timeout_err pulses exactly one cycle, 4 cycles after INSERV entry; state returns to IDLE.
REQ-032 eoi coincident with the timeout cycle -> no timeout_err; return to IDLE.
REQ-033 PRESETn low during INSERV -> all outputs 0 on the next edge; after release, irq_status=0x80 -> vec 7.
